fifo_read_checker: RTL and testbench
====================================

FIFO_READ_CHECKER -- requirements
Module: fifo_read_checker

Interface
REQ-001 Parameter: RD_LAT, 1, FIFO read latency in cycles from RE sampled high to DOUT valid; legal values 1..3.
REQ-002 Parameter: SEED, 8'h01, reference LFSR reset value; must be nonzero.
REQ-003 Parameter: CNT_W, 16, width of RD_CNT and ERR_CNT.
REQ-004 Port: clk  in  1  single clock; all state updates on the posedge.
REQ-005 Port: RESET  in  1  asynchronous, active-high reset.
REQ-006 Port: EN  in  1  drain enable.
REQ-007 Port: DOUT  in  8  FIFO read data.
REQ-008 Port: EF  in  1  FIFO empty flag.
REQ-009 Port: PEF  in  1  FIFO partially-empty flag.
REQ-010 Port: RE  out  1  FIFO read enable.
REQ-011 Port: EXP_DATA  out  8  current expected word.
REQ-012 Port: MATCH  out  1  one-cycle pulse: checked word equal.
REQ-013 Port: ERR  out  1  one-cycle pulse: checked word mismatched.
REQ-014 Port: RD_CNT  out  CNT_W  words checked, wraps.
REQ-015 Port: ERR_CNT  out  CNT_W  mismatches, saturates at all-ones.
REQ-016 Port: BUSY  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, DRAIN, FLUSH.
REQ-018 IDLE -> DRAIN when EN=1 and EF=0 (see REQ-031 for the macro variant).
REQ-019 DRAIN -> FLUSH when EF=1 or EN=0.
REQ-020 FLUSH -> IDLE once no reads are in flight.
REQ-021 RE is combinational: RE = (state==DRAIN) & EN & ~EF. RE is never high in IDLE or FLUSH.
REQ-022 Each posedge with RE=1 enters a valid token into an RD_LAT-deep shift pipe. A token leaving the pipe marks DOUT as valid in that cycle.
REQ-023 On a valid cycle, DOUT is compared with EXP_DATA. The result is registered: MATCH or ERR is high for exactly the following cycle, and never both.
REQ-024 On each valid cycle, RD_CNT increments by 1 and wraps modulo 2^CNT_W. ERR_CNT increments on mismatch and holds once it reaches all-ones.
REQ-025 EXP_DATA is an 8-bit Fibonacci LFSR with polynomial x^8+x^6+x^5+x^4+1, shift-left, feedback into bit 0. It advances exactly once per valid cycle, whether the word matched or not.
REQ-026 If EF rises in the same cycle RE would assert, RE stays low. An EF=1 pulse of a single cycle during DRAIN still forces FLUSH.
REQ-027 If EN drops mid-DRAIN, in-flight words are still checked and counted. No new reads are issued.
REQ-028 If EN and ~EF hold in FLUSH, the FSM returns to IDLE first and re-enters DRAIN no earlier than the next cycle.

Reset
REQ-029 While RESET=1: state=IDLE, RE=0, EXP_DATA=SEED, MATCH=0, ERR=0, RD_CNT=0, ERR_CNT=0, BUSY=0, and the valid pipe is cleared.
REQ-030 Reset mid-operation discards in-flight tokens, with no MATCH/ERR pulse for them. Checking restarts at SEED after RESET falls.

Configuration
REQ-031 Macro FIFO_RD_BURST_EN. When defined, IDLE -> DRAIN additionally requires PEF=0, so the reader waits for the FIFO to pass the partially-empty threshold, then drains until EF. When undefined, PEF is ignored.

Structure
REQ-032 Package fifo_chk_pkg holds: the FSM state enum, DATA_W=8, the LFSR tap mask 8'hB8, and the default SEED.
REQ-033 Sub-module lfsr_ref holds the reference LFSR. It has clk, RESET, an advance input, a SEED parameter, and a value output.

Verification
REQ-034 Scenario: RESET pulse, then EN=1 with EF=1 held. Required: RE never asserts, BUSY=0, RD_CNT=0.
REQ-035 Scenario: FIFO model preloaded with 8 LFSR words from seed 8'h01 (01,02,04,08,11,23,47,8E), EN=1. Required: 8 MATCH pulses, RD_CNT=8, ERR_CNT=0, FSM ends in IDLE.
REQ-036 Scenario: same stream with the 3rd word corrupted to 8'h05. Required: one ERR pulse on the 3rd check, ERR_CNT=1, the 4th word (08) still MATCHes.
REQ-037 Scenario: EN dropped after 2 reads with RD_LAT=2. Required: the in-flight words are checked, RD_CNT=2 or 3 per tokens issued, FLUSH -> IDLE, no further RE.
REQ-038 Scenario: RESET asserted while 1 token is in flight. Required: no MATCH/ERR pulse, EXP_DATA=8'h01, all counts 0.
REQ-039 Scenario: with FIFO_RD_BURST_EN, EF=0 and PEF=1. Required: RE stays 0 until PEF falls, then drains until EF=1.

Source files
------------

// File: rtl/fifo_chk_pkg.sv
// rtl/fifo_chk_pkg.sv - shared types, constants and LFSR step for the FIFO read checker
package fifo_chk_pkg;

  localparam int                DATA_W       = 8;
  // x^8+x^6+x^5+x^4+1 in shift-left form: taps on bits 7,5,4,3
  localparam logic [DATA_W-1:0] LFSR_TAPS    = 8'hB8;
  localparam logic [DATA_W-1:0] DEFAULT_SEED = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } chk_state_e;

  // One Fibonacci step: shift left, parity of tapped bits feeds bit 0
  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] v);
    return {v[DATA_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_ref.sv
// rtl/lfsr_ref.sv - reference LFSR producing the expected FIFO word stream
module lfsr_ref
  import fifo_chk_pkg::*;
#(
  parameter logic [DATA_W-1:0] SEED = DEFAULT_SEED  // must be nonzero
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              advance_i,
  output logic [DATA_W-1:0] value_o
);

  logic [DATA_W-1:0] value_q;

  // Step once per checked word; restart at SEED on reset
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      value_q <= SEED;
    end else if (advance_i) begin
      value_q <= lfsr_next(value_q);
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/fifo_read_checker.sv
// rtl/fifo_read_checker.sv - drains a FIFO and checks words against an LFSR stream (option macro: FIFO_RD_BURST_EN)
module fifo_read_checker
  import fifo_chk_pkg::*;
#(
  parameter int                RD_LAT = 1,             // FIFO read latency, 1..3
  parameter logic [DATA_W-1:0] SEED   = DEFAULT_SEED,  // nonzero
  parameter int                CNT_W  = 16
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              EN,
  input  logic [DATA_W-1:0] DOUT,
  input  logic              EF,
  input  logic              PEF,
  output logic              RE,
  output logic [DATA_W-1:0] EXP_DATA,
  output logic              MATCH,
  output logic              ERR,
  output logic [CNT_W-1:0]  RD_CNT,
  output logic [CNT_W-1:0]  ERR_CNT,
  output logic              BUSY
);

`ifdef FIFO_RD_BURST_EN
  // Hold off draining until the FIFO has filled past its partially-empty mark
  localparam logic PEF_GATES_START = 1'b1;
`else
  localparam logic PEF_GATES_START = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  chk_state_e        state_q;
  logic [RD_LAT-1:0] vld_pipe_q;
  logic [RD_LAT-1:0] vld_pipe_d;
  logic              match_q;
  logic              err_q;
  logic [CNT_W-1:0]  rd_cnt_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic              start_ok;
  logic              in_flight;
  logic              word_vld;
  logic              word_hit;

  // Read only while draining; EF masks RE in the same cycle it rises
  assign RE        = (state_q == ST_DRAIN) & EN & ~EF;
  assign start_ok  = EN & ~EF & ~(PEF & PEF_GATES_START);
  assign in_flight = |vld_pipe_q;
  assign word_vld  = vld_pipe_q[RD_LAT-1];
  assign word_hit  = (DOUT == EXP_DATA);

  // Control FSM; FLUSH always passes through IDLE before a new drain
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start_ok)    state_q <= ST_DRAIN;
        ST_DRAIN: if (EF || !EN)   state_q <= ST_FLUSH;
        ST_FLUSH: if (!in_flight)  state_q <= ST_IDLE;
        default:                   state_q <= ST_IDLE;
      endcase
    end
  end

  // Next value of the read-token pipe: RE enters at bit 0, exits at the top
  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    vld_pipe_d[0] = RE;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
    end
  end

  // Token pipe, registered compare result and counters
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      vld_pipe_q <= '0;
      match_q    <= 1'b0;
      err_q      <= 1'b0;
      rd_cnt_q   <= '0;
      err_cnt_q  <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      match_q    <= word_vld & word_hit;
      err_q      <= word_vld & ~word_hit;
      if (word_vld) begin
        rd_cnt_q <= rd_cnt_q + CNT_ONE;
        if (!word_hit && !(&err_cnt_q)) begin
          err_cnt_q <= err_cnt_q + CNT_ONE;
        end
      end
    end
  end

  lfsr_ref #(
    .SEED (SEED)
  ) u_lfsr (
    .clk       (clk),
    .RESET     (RESET),
    .advance_i (word_vld),
    .value_o   (EXP_DATA)
  );

  assign MATCH   = match_q;
  assign ERR     = err_q;
  assign RD_CNT  = rd_cnt_q;
  assign ERR_CNT = err_cnt_q;
  assign BUSY    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_read_checker.sv
// tb/tb_fifo_read_checker.sv - directed self-checking bench for fifo_read_checker
module tb_fifo_read_checker;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       EN = 1'b0;
  logic       PEF = 1'b0;
  logic       ef_force = 1'b0;
  logic [7:0] DOUT;
  logic       EF;
  logic       RE;
  logic [7:0] EXP_DATA;
  logic       MATCH;
  logic       ERR;
  logic [3:0] RD_CNT;
  logic [3:0] ERR_CNT;
  logic       BUSY;

  logic [7:0] mem [0:31];
  logic [7:0] dline [0:1];
  logic [7:0] lfsr_tab [0:8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};
  logic [4:0] rp_idx;
  logic       re_smp = 1'b0;
  logic       res [0:31];
  int         rp = 0;
  int         wp = 0;
  int         pops = 0;
  int         n_match = 0;
  int         n_err = 0;
  int         n_chk = 0;
  int         both_seen = 0;
  int         re_after = 0;
  logic       re_watch = 1'b0;
  int         tests_run = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  fifo_read_checker #(
    .RD_LAT (2),
    .SEED   (8'h01),
    .CNT_W  (4)
  ) dut (
    .clk      (clk),
    .RESET    (RESET),
    .EN       (EN),
    .DOUT     (DOUT),
    .EF       (EF),
    .PEF      (PEF),
    .RE       (RE),
    .EXP_DATA (EXP_DATA),
    .MATCH    (MATCH),
    .ERR      (ERR),
    .RD_CNT   (RD_CNT),
    .ERR_CNT  (ERR_CNT),
    .BUSY     (BUSY)
  );

  // FIFO model: read latency 2, empty when all stored words are popped
  assign EF   = (rp == wp) || ef_force;
  assign DOUT = dline[1];

  always @(posedge clk) re_smp <= RE;

  always @(negedge clk) begin
    dline[1] = dline[0];
    if (re_smp && !RESET) begin
      rp_idx   = rp[4:0];
      dline[0] = mem[rp_idx];
      rp       = rp + 1;
      pops     = pops + 1;
    end else begin
      dline[0] = 8'h00;
    end
  end

  always @(negedge clk) begin
    if (MATCH) begin
      if (n_chk < 32) res[n_chk] = 1'b1;
      n_chk   = n_chk + 1;
      n_match = n_match + 1;
    end
    if (ERR) begin
      if (n_chk < 32) res[n_chk] = 1'b0;
      n_chk = n_chk + 1;
      n_err = n_err + 1;
    end
    if (MATCH && ERR) both_seen = both_seen + 1;
    if (re_watch && RE) re_after = re_after + 1;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clr_mon();
    n_match = 0; n_err = 0; n_chk = 0; both_seen = 0; re_after = 0; re_watch = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1; EN = 1'b0; PEF = 1'b0; ef_force = 1'b0;
    rp = 0; wp = 0; pops = 0; dline[0] = 8'h00; dline[1] = 8'h00;
    tick(2);
    RESET = 1'b0;
    clr_mon();
    tick(1);
  endtask

  task automatic load(input int n, input int cidx, input logic [7:0] cval);
    for (int i = 0; i < n; i++) mem[i] = (i == cidx) ? cval : lfsr_tab[i];
    wp = n;
  endtask

  task automatic test_reset();
    RESET = 1'b1; EN = 1'b1;
    tick(1);
    tests_run++; if (RE !== 1'b0) begin fails++; $display("FAIL rst_re: got %b exp 0", RE); end
    tests_run++; if (BUSY !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b exp 0", BUSY); end
    tests_run++; if (EXP_DATA !== 8'h01) begin fails++; $display("FAIL rst_exp: got %h exp 01", EXP_DATA); end
    tests_run++; if ({MATCH, ERR} !== 2'b00) begin fails++; $display("FAIL rst_pulses: got %b exp 00", {MATCH, ERR}); end
    tests_run++; if (RD_CNT !== 4'd0) begin fails++; $display("FAIL rst_rdcnt: got %0d exp 0", RD_CNT); end
    tests_run++; if (ERR_CNT !== 4'd0) begin fails++; $display("FAIL rst_errcnt: got %0d exp 0", ERR_CNT); end
    EN = 1'b0;
  endtask

  task automatic test_empty_hold();
    int bad = 0;
    do_reset();
    EN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (RE || BUSY) bad++;
    end
    tests_run++; if (bad !== 0) begin fails++; $display("FAIL empty_re_busy: got %0d active cycles exp 0", bad); end
    tests_run++; if (RD_CNT !== 4'd0) begin fails++; $display("FAIL empty_rdcnt: got %0d exp 0", RD_CNT); end
  endtask

  task automatic test_drain();
    do_reset();
    load(8, -1, 8'h00);
    EN = 1'b1;
    tick(30);
    tests_run++; if (n_match !== 8) begin fails++; $display("FAIL drain_match: got %0d exp 8", n_match); end
    tests_run++; if (n_err !== 0) begin fails++; $display("FAIL drain_err: got %0d exp 0", n_err); end
    tests_run++; if (RD_CNT !== 4'd8) begin fails++; $display("FAIL drain_rdcnt: got %0d exp 8", RD_CNT); end
    tests_run++; if (ERR_CNT !== 4'd0) begin fails++; $display("FAIL drain_errcnt: got %0d exp 0", ERR_CNT); end
    tests_run++; if (BUSY !== 1'b0) begin fails++; $display("FAIL drain_idle: got %b exp 0", BUSY); end
    tests_run++; if (EXP_DATA !== 8'h1C) begin fails++; $display("FAIL drain_exp: got %h exp 1c", EXP_DATA); end
    tests_run++; if (pops !== 8) begin fails++; $display("FAIL drain_reads: got %0d exp 8", pops); end
    tests_run++; if (both_seen !== 0) begin fails++; $display("FAIL drain_both: got %0d exp 0", both_seen); end
  endtask

  task automatic test_corrupt();
    do_reset();
    load(8, 2, 8'h05);
    EN = 1'b1;
    tick(30);
    tests_run++; if (n_err !== 1) begin fails++; $display("FAIL corr_err: got %0d exp 1", n_err); end
    tests_run++; if (n_match !== 7) begin fails++; $display("FAIL corr_match: got %0d exp 7", n_match); end
    tests_run++; if (res[2] !== 1'b0) begin fails++; $display("FAIL corr_third: got %b exp 0", res[2]); end
    tests_run++; if (res[3] !== 1'b1) begin fails++; $display("FAIL corr_fourth: got %b exp 1", res[3]); end
    tests_run++; if (ERR_CNT !== 4'd1) begin fails++; $display("FAIL corr_errcnt: got %0d exp 1", ERR_CNT); end
    tests_run++; if (EXP_DATA !== 8'h1C) begin fails++; $display("FAIL corr_exp: got %h exp 1c", EXP_DATA); end
  endtask

  task automatic test_en_drop();
    do_reset();
    load(8, -1, 8'h00);
    EN = 1'b1;
    tick(1);
    tests_run++; if (RE !== 1'b1) begin fails++; $display("FAIL endrop_start: got %b exp 1", RE); end
    tick(2);
    EN = 1'b0;
    re_watch = 1'b1;
    tick(1);
    tests_run++; if (BUSY !== 1'b1) begin fails++; $display("FAIL endrop_flush: got %b exp 1", BUSY); end
    tick(10);
    tests_run++; if (RD_CNT !== 4'd2) begin fails++; $display("FAIL endrop_rdcnt: got %0d exp 2", RD_CNT); end
    tests_run++; if (n_match !== 2) begin fails++; $display("FAIL endrop_match: got %0d exp 2", n_match); end
    tests_run++; if (pops !== 2) begin fails++; $display("FAIL endrop_reads: got %0d exp 2", pops); end
    tests_run++; if (re_after !== 0) begin fails++; $display("FAIL endrop_re: got %0d exp 0", re_after); end
    tests_run++; if (BUSY !== 1'b0) begin fails++; $display("FAIL endrop_idle: got %b exp 0", BUSY); end
    tests_run++; if (EXP_DATA !== 8'h04) begin fails++; $display("FAIL endrop_exp: got %h exp 04", EXP_DATA); end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    load(1, -1, 8'h00);
    EN = 1'b1;
    tick(2);
    tests_run++; if (BUSY !== 1'b1) begin fails++; $display("FAIL rstfl_busy: got %b exp 1", BUSY); end
    RESET = 1'b1; EN = 1'b0;
    clr_mon();
    tick(3);
    tests_run++; if (n_match + n_err !== 0) begin fails++; $display("FAIL rstfl_pulse: got %0d exp 0", n_match + n_err); end
    tests_run++; if (EXP_DATA !== 8'h01) begin fails++; $display("FAIL rstfl_exp: got %h exp 01", EXP_DATA); end
    RESET = 1'b0;
    tick(4);
    tests_run++; if (n_match + n_err !== 0) begin fails++; $display("FAIL rstfl_after: got %0d exp 0", n_match + n_err); end
    tests_run++; if ({RD_CNT, ERR_CNT} !== 8'h00) begin fails++; $display("FAIL rstfl_cnts: got %h exp 00", {RD_CNT, ERR_CNT}); end
  endtask

  task automatic test_ef_pulse();
    do_reset();
    load(8, -1, 8'h00);
    EN = 1'b1;
    tick(1);
    tests_run++; if (RE !== 1'b1) begin fails++; $display("FAIL efp_start: got %b exp 1", RE); end
    tick(2);
    ef_force = 1'b1;
    #1;
    tests_run++; if (RE !== 1'b0) begin fails++; $display("FAIL efp_mask: got %b exp 0", RE); end
    tick(1);
    ef_force = 1'b0;
    #1;
    tests_run++; if ({BUSY, RE} !== 2'b10) begin fails++; $display("FAIL efp_flush: got %b exp 10", {BUSY, RE}); end
    tick(2);
    tests_run++; if ({BUSY, RE} !== 2'b00) begin fails++; $display("FAIL efp_idle_gap: got %b exp 00", {BUSY, RE}); end
    tick(1);
    tests_run++; if (RE !== 1'b1) begin fails++; $display("FAIL efp_redrain: got %b exp 1", RE); end
    tick(30);
    tests_run++; if (n_match !== 8) begin fails++; $display("FAIL efp_match: got %0d exp 8", n_match); end
    tests_run++; if (RD_CNT !== 4'd8) begin fails++; $display("FAIL efp_rdcnt: got %0d exp 8", RD_CNT); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 20; i++) mem[i] = 8'h00;
    wp = 20;
    EN = 1'b1;
    tick(45);
    tests_run++; if (ERR_CNT !== 4'hF) begin fails++; $display("FAIL sat_errcnt: got %0d exp 15", ERR_CNT); end
    tests_run++; if (RD_CNT !== 4'd4) begin fails++; $display("FAIL sat_rdwrap: got %0d exp 4", RD_CNT); end
    tests_run++; if (n_err !== 20) begin fails++; $display("FAIL sat_errpulses: got %0d exp 20", n_err); end
  endtask

  task automatic test_burst();
    do_reset();
    load(8, -1, 8'h00);
    PEF = 1'b1;
    EN = 1'b1;
`ifdef FIFO_RD_BURST_EN
    re_watch = 1'b1;
    tick(6);
    tests_run++; if (re_after !== 0) begin fails++; $display("FAIL burst_hold: got %0d RE cycles exp 0", re_after); end
    tests_run++; if (BUSY !== 1'b0) begin fails++; $display("FAIL burst_idle: got %b exp 0", BUSY); end
    PEF = 1'b0;
    re_watch = 1'b0;
`endif
    tick(30);
    tests_run++; if (n_match !== 8) begin fails++; $display("FAIL burst_match: got %0d exp 8", n_match); end
    tests_run++; if (BUSY !== 1'b0) begin fails++; $display("FAIL burst_done: got %b exp 0", BUSY); end
  endtask

  initial begin
    dline[0] = 8'h00;
    dline[1] = 8'h00;
    test_reset();
    test_empty_hold();
    test_drain();
    test_corrupt();
    test_en_drop();
    test_reset_inflight();
    test_ef_pulse();
    test_saturate();
    test_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
